// File: rtl/reg_load_arbiter_if.sv
// Handshake and register-load bus shared by the two requesters, the arbiter
// and the operand register bank.
interface reg_load_arbiter_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2
);
    logic                req0_valid;
    logic [ADDR_W-1:0]   req0_addr;
    logic [DATA_W-1:0]   req0_data;
    logic                req0_ready;
    logic                req1_valid;
    logic [ADDR_W-1:0]   req1_addr;
    logic [DATA_W-1:0]   req1_data;
    logic                req1_ready;
    logic [NUM_REGS-1:0] load;
    logic [DATA_W-1:0]   data_out;
    logic                busy;
    logic                addr_err;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  load, data_out, busy, addr_err
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output load, data_out, busy, addr_err
    );
endinterface

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter between two requesters sharing one register load path;
// every grant produces LOAD then GAP, so at most one transfer per 3 cycles.
module reg_load_arbiter #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_load_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, GAP} StateT;

    StateT               state;
    StateT               stateNext;
    logic                lastGrant;
    logic                lastGrantNext;
    logic                anyValid;
    logic                grant0;
    logic [ADDR_W-1:0]   winAddr;
    logic [DATA_W-1:0]   winData;
    logic [NUM_REGS-1:0] addrDecode;
    logic                inRange;

    logic [NUM_REGS-1:0] loadReg,   loadNext;
    logic [DATA_W-1:0]   dataReg,   dataNext;
    logic                ready0Reg, ready0Next;
    logic                ready1Reg, ready1Next;
    logic                busyReg,   busyNext;
    logic                errReg,    errNext;

    // State, grant history and every output are registered together, so a
    // grant decided at an IDLE edge is visible as the LOAD cycle right after.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
            loadReg   <= '0;
            dataReg   <= '0;
            ready0Reg <= 1'b0;
            ready1Reg <= 1'b0;
            busyReg   <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            state     <= stateNext;
            lastGrant <= lastGrantNext;
            loadReg   <= loadNext;
            dataReg   <= dataNext;
            ready0Reg <= ready0Next;
            ready1Reg <= ready1Next;
            busyReg   <= busyNext;
            errReg    <= errNext;
        end
    end

    // lastGrant high means requester 1 was served last, so requester 0 wins a tie.
    always_comb begin
        anyValid  = bus.req0_valid || bus.req1_valid;
        grant0    = bus.req0_valid && (!bus.req1_valid || lastGrant);
        stateNext = state;
        case (state)
            IDLE:    if (anyValid) stateNext = LOAD;
            LOAD:    stateNext = GAP;
            GAP:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        winAddr    = grant0 ? bus.req0_addr : bus.req1_addr;
        winData    = grant0 ? bus.req0_data : bus.req1_data;
        addrDecode = '0;
        inRange    = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (winAddr == ADDR_W'(i)) begin
                addrDecode[i] = 1'b1;
                inRange       = 1'b1;
            end
        end

        loadNext      = '0;
        dataNext      = dataReg;
        ready0Next    = 1'b0;
        ready1Next    = 1'b0;
        errNext       = 1'b0;
        lastGrantNext = lastGrant;
        busyNext      = (stateNext != IDLE);

        // An out-of-range address still completes the handshake, just without a strobe.
        if (state == IDLE && anyValid) begin
            loadNext      = addrDecode;
            errNext       = !inRange;
            dataNext      = winData;
            ready0Next    = grant0;
            ready1Next    = !grant0;
            lastGrantNext = !grant0;
        end
    end

    assign bus.load       = loadReg;
    assign bus.data_out   = dataReg;
    assign bus.req0_ready = ready0Reg;
    assign bus.req1_ready = ready1Reg;
    assign bus.busy       = busyReg;
    assign bus.addr_err   = errReg;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed bench for reg_load_arbiter: a 4-register instance for the main
// scenarios and a 3-register instance for out-of-range addresses.
module tb_reg_load_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_load_arbiter_if #(.DATA_W(16), .NUM_REGS(4), .ADDR_W(2)) busA ();
    reg_load_arbiter_if #(.DATA_W(16), .NUM_REGS(3), .ADDR_W(2)) busB ();

    reg_load_arbiter #(.DATA_W(16), .NUM_REGS(4), .ADDR_W(2)) dutA (
        .clk(clk), .rst_n(rst_n), .bus(busA));
    reg_load_arbiter #(.DATA_W(16), .NUM_REGS(3), .ADDR_W(2)) dutB (
        .clk(clk), .rst_n(rst_n), .bus(busB));

    // Operand register banks fed by the load strobes.
    logic [15:0] regsA [4];
    logic [15:0] regsB [3];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (!rst_n) regsA[i] <= 16'h0;
            else if (busA.load[i]) regsA[i] <= busA.data_out;
        for (int i = 0; i < 3; i++)
            if (!rst_n) regsB[i] <= 16'h0;
            else if (busB.load[i]) regsB[i] <= busB.data_out;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        busA.req0_valid = 1'b0; busA.req0_addr = '0; busA.req0_data = '0;
        busA.req1_valid = 1'b0; busA.req1_addr = '0; busA.req1_data = '0;
        busB.req0_valid = 1'b0; busB.req0_addr = '0; busB.req0_data = '0;
        busB.req1_valid = 1'b0; busB.req1_addr = '0; busB.req1_data = '0;
        tick(); tick();
        checks++; if (busA.load !== 4'b0000) begin errors++; $display("[TB] FAIL reset_load got %b expected 0000", busA.load); end
        checks++; if (busA.data_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data got %h expected 0000", busA.data_out); end
        checks++; if ({busA.req1_ready, busA.req0_ready} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready got %b expected 00", {busA.req1_ready, busA.req0_ready}); end
        checks++; if ({busA.busy, busA.addr_err} !== 2'b00) begin errors++; $display("[TB] FAIL reset_busy_err got %b expected 00", {busA.busy, busA.addr_err}); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        busA.req0_valid = 1'b1; busA.req0_addr = 2'd2; busA.req0_data = 16'h00FE;
        tick();
        checks++; if (busA.load !== 4'b0100) begin errors++; $display("[TB] FAIL single_load got %b expected 0100", busA.load); end
        checks++; if (busA.data_out !== 16'h00FE) begin errors++; $display("[TB] FAIL single_data got %h expected 00fe", busA.data_out); end
        checks++; if ({busA.req1_ready, busA.req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL single_ready got %b expected 01", {busA.req1_ready, busA.req0_ready}); end
        checks++; if (busA.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_load got %b expected 1", busA.busy); end
        busA.req0_valid = 1'b0;
        tick();
        checks++; if (busA.load !== 4'b0000) begin errors++; $display("[TB] FAIL single_gap_load got %b expected 0000", busA.load); end
        checks++; if ({busA.req1_ready, busA.req0_ready} !== 2'b00) begin errors++; $display("[TB] FAIL single_gap_ready got %b expected 00", {busA.req1_ready, busA.req0_ready}); end
        checks++; if (busA.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_gap got %b expected 1", busA.busy); end
        checks++; if (busA.data_out !== 16'h00FE) begin errors++; $display("[TB] FAIL single_data_hold got %h expected 00fe", busA.data_out); end
        checks++; if (regsA[2] !== 16'h00FE) begin errors++; $display("[TB] FAIL single_reg2 got %h expected 00fe", regsA[2]); end
        tick();
        checks++; if (busA.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_idle got %b expected 0", busA.busy); end
    endtask

    task automatic test_simultaneous();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        busA.req0_valid = 1'b1; busA.req0_addr = 2'd0; busA.req0_data = 16'h0FE6;
        busA.req1_valid = 1'b1; busA.req1_addr = 2'd1; busA.req1_data = 16'h1234;
        tick();
        checks++; if (busA.load !== 4'b0001) begin errors++; $display("[TB] FAIL tie1_load got %b expected 0001", busA.load); end
        checks++; if ({busA.req1_ready, busA.req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL tie1_ready got %b expected 01", {busA.req1_ready, busA.req0_ready}); end
        checks++; if (busA.data_out !== 16'h0FE6) begin errors++; $display("[TB] FAIL tie1_data got %h expected 0fe6", busA.data_out); end
        busA.req0_valid = 1'b0;
        tick();
        tick();
        checks++; if (busA.load !== 4'b0000) begin errors++; $display("[TB] FAIL tie1_idle_load got %b expected 0000", busA.load); end
        tick();
        checks++; if (busA.load !== 4'b0010) begin errors++; $display("[TB] FAIL tie1_second_load got %b expected 0010", busA.load); end
        checks++; if ({busA.req1_ready, busA.req0_ready} !== 2'b10) begin errors++; $display("[TB] FAIL tie1_second_ready got %b expected 10", {busA.req1_ready, busA.req0_ready}); end
        checks++; if (busA.data_out !== 16'h1234) begin errors++; $display("[TB] FAIL tie1_second_data got %h expected 1234", busA.data_out); end
        busA.req1_valid = 1'b0;
        tick();
        checks++; if (regsA[0] !== 16'h0FE6) begin errors++; $display("[TB] FAIL tie1_reg0 got %h expected 0fe6", regsA[0]); end
        checks++; if (regsA[1] !== 16'h1234) begin errors++; $display("[TB] FAIL tie1_reg1 got %h expected 1234", regsA[1]); end
        tick();
        busA.req0_valid = 1'b1; busA.req0_addr = 2'd3; busA.req0_data = 16'h0F0F;
        busA.req1_valid = 1'b1; busA.req1_addr = 2'd2; busA.req1_data = 16'h2222;
        tick();
        checks++; if (busA.load !== 4'b1000) begin errors++; $display("[TB] FAIL tie2_load got %b expected 1000", busA.load); end
        checks++; if ({busA.req1_ready, busA.req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL tie2_ready got %b expected 01", {busA.req1_ready, busA.req0_ready}); end
        busA.req0_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (busA.load !== 4'b0100) begin errors++; $display("[TB] FAIL tie2_second_load got %b expected 0100", busA.load); end
        checks++; if ({busA.req1_ready, busA.req0_ready} !== 2'b10) begin errors++; $display("[TB] FAIL tie2_second_ready got %b expected 10", {busA.req1_ready, busA.req0_ready}); end
        busA.req1_valid = 1'b0;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        int  nXfer = 0;
        int  lastCycle = -1;
        int  cyc = 0;
        bit  expectReq1 = 1'b0;
        busA.req0_valid = 1'b1; busA.req0_addr = 2'd1; busA.req0_data = 16'h1111;
        busA.req1_valid = 1'b1; busA.req1_addr = 2'd3; busA.req1_data = 16'h3333;
        while (nXfer < 8 && cyc < 40) begin
            tick();
            cyc++;
            checks++; if ($countones(busA.load) > 1) begin errors++; $display("[TB] FAIL b2b_onehot got %b expected at most one bit", busA.load); end
            if (busA.load != 4'b0000) begin
                checks++; if (busA.load !== (expectReq1 ? 4'b1000 : 4'b0010)) begin errors++; $display("[TB] FAIL b2b_load xfer %0d got %b expected %b", nXfer, busA.load, expectReq1 ? 4'b1000 : 4'b0010); end
                checks++; if ({busA.req1_ready, busA.req0_ready} !== (expectReq1 ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL b2b_ready xfer %0d got %b expected %b", nXfer, {busA.req1_ready, busA.req0_ready}, expectReq1 ? 2'b10 : 2'b01); end
                if (lastCycle >= 0) begin
                    checks++; if (cyc - lastCycle != 3) begin errors++; $display("[TB] FAIL b2b_spacing xfer %0d got %0d expected 3", nXfer, cyc - lastCycle); end
                end
                lastCycle  = cyc;
                expectReq1 = !expectReq1;
                nXfer++;
            end
        end
        checks++; if (nXfer != 8) begin errors++; $display("[TB] FAIL b2b_count got %0d expected 8", nXfer); end
        busA.req0_valid = 1'b0;
        busA.req1_valid = 1'b0;
        tick(); tick();
    endtask

    task automatic test_latch_isolation();
        busA.req0_valid = 1'b1; busA.req0_addr = 2'd0; busA.req0_data = 16'hAAAA;
        tick();
        busA.req0_data  = 16'h5555;
        busA.req0_valid = 1'b0;
        checks++; if (busA.data_out !== 16'hAAAA) begin errors++; $display("[TB] FAIL latch_data got %h expected aaaa", busA.data_out); end
        tick();
        checks++; if (regsA[0] !== 16'hAAAA) begin errors++; $display("[TB] FAIL latch_reg0 got %h expected aaaa", regsA[0]); end
        checks++; if (busA.data_out !== 16'hAAAA) begin errors++; $display("[TB] FAIL latch_hold got %h expected aaaa", busA.data_out); end
        tick();
    endtask

    task automatic test_reset_mid();
        busA.req0_valid = 1'b1; busA.req0_addr = 2'd2; busA.req0_data = 16'h7777;
        tick();
        checks++; if (busA.req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got %b expected 1", busA.req0_ready); end
        busA.req0_valid = 1'b0;
        tick();
        checks++; if (busA.busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_gap_busy got %b expected 1", busA.busy); end
        rst_n = 1'b0;
        tick();
        checks++; if (busA.load !== 4'b0000) begin errors++; $display("[TB] FAIL mid_load got %b expected 0000", busA.load); end
        checks++; if (busA.data_out !== 16'h0000) begin errors++; $display("[TB] FAIL mid_data got %h expected 0000", busA.data_out); end
        checks++; if ({busA.busy, busA.addr_err, busA.req1_ready, busA.req0_ready} !== 4'b0000) begin errors++; $display("[TB] FAIL mid_flags got %b expected 0000", {busA.busy, busA.addr_err, busA.req1_ready, busA.req0_ready}); end
        rst_n = 1'b1;
        busA.req0_valid = 1'b1; busA.req0_addr = 2'd2; busA.req0_data = 16'h4444;
        busA.req1_valid = 1'b1; busA.req1_addr = 2'd3; busA.req1_data = 16'h5A5A;
        tick();
        checks++; if (busA.load !== 4'b0100) begin errors++; $display("[TB] FAIL mid_tie_load got %b expected 0100", busA.load); end
        checks++; if ({busA.req1_ready, busA.req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL mid_tie_ready got %b expected 01", {busA.req1_ready, busA.req0_ready}); end
        busA.req0_valid = 1'b0;
        busA.req1_valid = 1'b0;
        tick(); tick();
    endtask

    task automatic test_addr_range();
        busB.req0_valid = 1'b1; busB.req0_addr = 2'd1; busB.req0_data = 16'h0B0B;
        tick();
        checks++; if (busB.load !== 3'b010) begin errors++; $display("[TB] FAIL range_valid_load got %b expected 010", busB.load); end
        busB.req0_valid = 1'b0;
        tick(); tick();
        busB.req1_valid = 1'b1; busB.req1_addr = 2'd3; busB.req1_data = 16'hBEEF;
        tick();
        checks++; if (busB.load !== 3'b000) begin errors++; $display("[TB] FAIL range_load got %b expected 000", busB.load); end
        checks++; if (busB.addr_err !== 1'b1) begin errors++; $display("[TB] FAIL range_err got %b expected 1", busB.addr_err); end
        checks++; if ({busB.req1_ready, busB.req0_ready} !== 2'b10) begin errors++; $display("[TB] FAIL range_ready got %b expected 10", {busB.req1_ready, busB.req0_ready}); end
        busB.req1_valid = 1'b0;
        tick();
        checks++; if (busB.addr_err !== 1'b0) begin errors++; $display("[TB] FAIL range_err_pulse got %b expected 0", busB.addr_err); end
        checks++; if ({regsB[2], regsB[1], regsB[0]} !== {16'h0000, 16'h0B0B, 16'h0000}) begin errors++; $display("[TB] FAIL range_regs got %h %h %h expected 0000 0b0b 0000", regsB[2], regsB[1], regsB[0]); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_back_to_back();
        test_latch_isolation();
        test_reset_mid();
        test_addr_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_load_arbiter.md
# reg_load_arbiter

Shares the 16-bit register load path between two requesters (host command path and internal sequencer). It arbitrates round-robin, latches the winning address and data, then drives a single one-cycle one-hot `load` strobe and the shared data bus into a bank of `NUM_REGS` operand registers. Each register captures on the posedge where its load input is high. The block sits between the command front-end and the operand/address registers of the controller datapath.

## Interface
- `DATA_W`, 16, width of the data bus and of each target register
- `NUM_REGS`, 4, number of target registers (one load strobe each)
- `ADDR_W`, 2, register address width; requires `NUM_REGS <= 2**ADDR_W`

- `clk`  in  1  single clock; everything samples on its rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req0_valid`  in  1  requester 0 has a load pending; held high until `req0_ready`
- `req0_addr`  in  ADDR_W  target register index for requester 0
- `req0_data`  in  DATA_W  value to load for requester 0
- `req0_ready`  out  1  one-cycle pulse; requester 0 transfer complete
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: same as requester 0, for requester 1
- `load`  out  NUM_REGS  one-hot load strobes to the target registers
- `data_out`  out  DATA_W  shared data bus to all target registers
- `busy`  out  1  high whenever the FSM is not IDLE
- `addr_err`  out  1  one-cycle pulse when a granted address is `>= NUM_REGS`

## Operation
- FSM states are IDLE, LOAD and GAP. All outputs are registered.
- IDLE behaviour:
  - Any `reqN_valid` high at an edge triggers a grant at that edge.
  - The winner's `addr` and `data` are latched internally, `last_grant` is updated, and the FSM moves to LOAD.
- Arbitration:
  - If only one valid is high, that requester wins.
  - If both are high, the winner is the requester not equal to `last_grant`.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- LOAD (exactly 1 cycle):
  - `load[addr]` = 1 and all other strobes are 0.
  - `data_out` = latched data.
  - The winner's `ready` = 1 and the other requester's `ready` = 0.
  - The next state is GAP.
- GAP (exactly 1 cycle):
  - `load` = 0 and both readies are 0.
  - `data_out` keeps its value.
  - The next state is IDLE, and new requests are sampled there.
- Out-of-range address (`addr >= NUM_REGS`):
  - LOAD still occurs with `load` = all zeros.
  - The winner's `ready` pulses normally.
  - `addr_err` = 1 for that LOAD cycle only.
- `data_out` holds the last granted value between transfers and only changes on entry to LOAD.
- Changes to a requester's `addr`/`data` after its grant edge have no effect, because the values are already latched.
- Dropping `valid` before `ready` is a protocol violation, but the grant already taken completes regardless.

## Timing
- Reset values: state IDLE, `load` = 0, `data_out` = 0, `req0_ready` = `req1_ready` = 0, `busy` = 0, `addr_err` = 0, `last_grant` = 1.
- `rst_n` low at an edge forces the reset values at that edge, overriding all other transitions.
- Reset mid-transfer:
  - Outputs present in the current cycle (including a LOAD cycle) are not retracted, so the target register captures normally at that edge.
  - From the next cycle all outputs are at their reset values.
- Latency:
  - `valid` sampled at edge k gives LOAD during cycle k..k+1.
  - The target register holds the new value after edge k+1.
- Throughput is one transfer per 3 cycles. With both requesters continuously valid, grants alternate 0,1,0,1…
- `busy` is high during LOAD and GAP and low in IDLE.
- A request arriving during LOAD or GAP is first eligible at the edge leaving GAP.

## Test plan
- Reset then single request: `rst_n` = 0 for 2 cycles, then `req0_valid` = 1, addr = 2, data = 16'h00FE.
  - Expect `load` = 4'b0100, `data_out` = 16'h00FE and `req0_ready` = 1 in the same single cycle.
  - Target reg 2 reads 16'h00FE afterwards.
  - `busy` is high for exactly 2 cycles.
- Simultaneous requests: req0 = (addr 0, 16'h0FE6) and req1 = (addr 1, 16'h1234) raised together and held until their ready.
  - Expect req0 served first, then req1 three cycles later.
  - Expect `load` = 0001 then 0010.
  - A second tie is won by req0 again only after req1 has been served.
- Back-to-back from both requesters for 8 transfers: grants strictly alternate, LOAD cycles are exactly 3 cycles apart, and no two strobes are ever high at once.
- Out-of-range address: with `NUM_REGS` = 3, req1 addr = 3.
  - Expect `load` = 0, `addr_err` = 1 and `req1_ready` = 1 in one cycle.
  - Target registers are unchanged.
- Latch isolation: change `req0_data` from 16'hAAAA to 16'h5555 one cycle after the grant edge. Expect the captured value to be 16'hAAAA.
- Reset mid-operation: assert `rst_n` = 0 during GAP. Expect all outputs at their reset values next cycle and `last_grant` = 1, so the next tie goes to req0.
